// File: rtl/opsum_wb_pkg.sv
// Shared types and constants for the opsum writeback drain engine.
package opsum_wb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        POP,
        CAPT,
        WRITE,
        DONE
    } state_t;

    localparam logic [3:0] WE_FULL = 4'b1111;
    localparam logic [3:0] WE_LO   = 4'b0011;
    localparam logic [3:0] WE_HI   = 4'b1100;

    localparam int INC32 = 4;
    localparam int INC16 = 2;

    // Negative opsums carry no information downstream, so they are clamped to zero.
    function automatic logic [15:0] relu16(input logic [15:0] v);
        return v[15] ? 16'h0000 : v;
    endfunction

endpackage

// File: rtl/opsum_rr_arb.sv
// Combinational round-robin finder: first set bit of eligible after last_ch, wrapping.
module opsum_rr_arb #(
    parameter int NUM_CH = 8,
    parameter int IDX_W  = 3
) (
    input  logic [NUM_CH-1:0] eligible,
    input  logic [IDX_W-1:0]  last_ch,
    output logic              hit,
    output logic [IDX_W-1:0]  idx
);

    logic [IDX_W-1:0] cand;

    // Walk from the farthest candidate to the nearest so the nearest hit is the one kept.
    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            cand = IDX_W'((int'(last_ch) + i) % NUM_CH);
            if (eligible[cand]) begin
                hit = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/opsum_writeback.sv
// Drains per-PE opsum FIFOs round-robin into the GLB; 32-bit pairs when full, 16-bit singles on flush.
// Optional OPSUM_WB_RELU_EN: clamp each negative 16-bit half to zero before placement.
module opsum_writeback
    import opsum_wb_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  flush,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W-1:0]     ch_stride,
    output logic                  busy,
    output logic                  done,
    input  logic [NUM_CH-1:0]     fifo_full,
    input  logic [NUM_CH-1:0]     fifo_empty,
    output logic [NUM_CH-1:0]     fifo_pop_en,
    output logic [NUM_CH-1:0]     fifo_pop_mod,
    input  logic [NUM_CH*32-1:0]  fifo_pop_data,
    output logic                  glb_req,
    input  logic                  glb_gnt,
    output logic [ADDR_W-1:0]     glb_addr,
    output logic [31:0]           glb_wdata,
    output logic [3:0]            glb_we
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    sel_q, sel_d;
    logic [IDX_W-1:0]    last_ch_q, last_ch_d;
    logic                mode32_q, mode32_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   stride_q, stride_d;
    logic [ADDR_W-1:0]   ch_off_q [NUM_CH];
    logic [ADDR_W-1:0]   ch_off_d [NUM_CH];

    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [NUM_CH-1:0]   pop_en_q, pop_en_d;
    logic [NUM_CH-1:0]   pop_mod_q, pop_mod_d;
    logic                req_q, req_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          we_q, we_d;

    logic [NUM_CH-1:0]   eligible;
    logic                all_empty;
    logic                arb_hit;
    logic [IDX_W-1:0]    arb_idx;
    logic                hit_mode32;
    logic [31:0]         pop_arr [NUM_CH];
    logic [31:0]         pop_word;
    logic [31:0]         pop_vals;
    logic [ADDR_W-1:0]   sel_off;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_pop_slice
            assign pop_arr[gi] = fifo_pop_data[gi*32 +: 32];
        end
    endgenerate

    assign eligible   = fifo_full | (flush ? ~fifo_empty : '0);
    assign all_empty  = &fifo_empty;
    assign pop_word   = pop_arr[sel_q];
    assign sel_off    = ch_off_q[sel_q];
    // A channel sitting on a half-word boundary takes one 16-bit pop to realign.
    assign hit_mode32 = fifo_full[arb_idx] && !ch_off_q[arb_idx][1];

`ifdef OPSUM_WB_RELU_EN
    assign pop_vals = {relu16(pop_word[31:16]), relu16(pop_word[15:0])};
`else
    assign pop_vals = pop_word;
`endif

    opsum_rr_arb #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_arb (
        .eligible (eligible),
        .last_ch  (last_ch_q),
        .hit      (arb_hit),
        .idx      (arb_idx)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_ch_d = last_ch_q;
        mode32_d  = mode32_q;
        base_d    = base_q;
        stride_d  = stride_q;
        ch_off_d  = ch_off_q;
        done_d    = 1'b0;
        pop_en_d  = '0;
        pop_mod_d = '0;
        req_d     = req_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d   = base_addr;
                    stride_d = ch_stride;
                    for (int i = 0; i < NUM_CH; i++) begin
                        ch_off_d[i] = '0;
                    end
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (arb_hit) begin
                    sel_d              = arb_idx;
                    mode32_d           = hit_mode32;
                    pop_en_d[arb_idx]  = 1'b1;
                    pop_mod_d[arb_idx] = hit_mode32;
                    state_d            = POP;
                end else if (flush && all_empty) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            POP: begin
                state_d = CAPT;
            end
            CAPT: begin
                last_ch_d = sel_q;
                addr_d    = base_q + ADDR_W'(sel_q) * stride_q + (sel_off & ~ADDR_W'(3));
                if (mode32_q) begin
                    wdata_d = pop_vals;
                    we_d    = WE_FULL;
                end else if (!sel_off[1]) begin
                    wdata_d = {16'h0000, pop_vals[15:0]};
                    we_d    = WE_LO;
                end else begin
                    wdata_d = {pop_vals[15:0], 16'h0000};
                    we_d    = WE_HI;
                end
                req_d   = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                if (glb_gnt) begin
                    req_d           = 1'b0;
                    ch_off_d[sel_q] = sel_off + (mode32_q ? ADDR_W'(INC32) : ADDR_W'(INC16));
                    state_d         = SCAN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            last_ch_q <= IDX_W'(NUM_CH - 1);
            mode32_q  <= 1'b0;
            base_q    <= '0;
            stride_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                ch_off_q[i] <= '0;
            end
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pop_en_q  <= '0;
            pop_mod_q <= '0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_ch_q <= last_ch_d;
            mode32_q  <= mode32_d;
            base_q    <= base_d;
            stride_q  <= stride_d;
            for (int i = 0; i < NUM_CH; i++) begin
                ch_off_q[i] <= ch_off_d[i];
            end
            busy_q    <= busy_d;
            done_q    <= done_d;
            pop_en_q  <= pop_en_d;
            pop_mod_q <= pop_mod_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign fifo_pop_en  = pop_en_q;
    assign fifo_pop_mod = pop_mod_q;
    assign glb_req      = req_q;
    assign glb_addr     = addr_q;
    assign glb_wdata    = wdata_q;
    assign glb_we       = we_q;

endmodule

// File: tb/tb_opsum_writeback.sv
// Bench for opsum_writeback: 4-channel FIFO model, directed vector table and multi-cycle sequences.
module tb_opsum_writeback;

    localparam int NCH = 4;
    localparam int NV  = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] base_addr = 32'h0;
    logic [31:0] ch_stride = 32'h0;
    logic        busy;
    logic        done;
    logic [NCH-1:0] fifo_full;
    logic [NCH-1:0] fifo_empty;
    logic [NCH-1:0] fifo_pop_en;
    logic [NCH-1:0] fifo_pop_mod;
    logic [NCH*32-1:0] fifo_pop_data;
    logic        glb_req;
    logic        glb_gnt = 1'b1;
    logic [31:0] glb_addr;
    logic [31:0] glb_wdata;
    logic [3:0]  glb_we;

    int n_err = 0;
    int n_chk = 0;
    int n_wr  = 0;

    always #5 clk = ~clk;

    opsum_writeback #(
        .NUM_CH (NCH),
        .ADDR_W (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .flush         (flush),
        .base_addr     (base_addr),
        .ch_stride     (ch_stride),
        .busy          (busy),
        .done          (done),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .fifo_pop_en   (fifo_pop_en),
        .fifo_pop_mod  (fifo_pop_mod),
        .fifo_pop_data (fifo_pop_data),
        .glb_req       (glb_req),
        .glb_gnt       (glb_gnt),
        .glb_addr      (glb_addr),
        .glb_wdata     (glb_wdata),
        .glb_we        (glb_we)
    );

    // ---------------- depth-2 FIFO model per channel ----------------
    typedef struct {
        int          ch;
        logic [15:0] d;
    } push_t;

    push_t       push_q[$];
    int          push_rd = 0;
    logic [15:0] mem [NCH][2];
    int          cnt [NCH] = '{default: 0};
    int          pops [NCH] = '{default: 0};
    logic [31:0] pdata [NCH] = '{default: 32'h0};
    logic [NCH-1:0] keep_full = '0;
    logic [15:0] fill_seq = 16'h0100;

    always @(posedge clk) begin : fifo_model
        int          n [NCH];
        logic [15:0] m [NCH][2];
        int          rd;
        logic [15:0] seq;
        rd  = push_rd;
        seq = fill_seq;
        for (int c = 0; c < NCH; c++) begin
            n[c]    = cnt[c];
            m[c][0] = mem[c][0];
            m[c][1] = mem[c][1];
            if (fifo_pop_en[c] && n[c] > 0) begin
                pops[c] <= pops[c] + 1;
                if (fifo_pop_mod[c]) begin
                    pdata[c] <= {m[c][1], m[c][0]};
                    n[c] = 0;
                end else begin
                    pdata[c] <= {16'h0000, m[c][0]};
                    m[c][0] = m[c][1];
                    n[c] = n[c] - 1;
                end
            end
        end
        while (rd < push_q.size()) begin
            if (n[push_q[rd].ch] == 0) begin
                m[push_q[rd].ch][0] = push_q[rd].d;
                n[push_q[rd].ch] = 1;
            end else if (n[push_q[rd].ch] == 1) begin
                m[push_q[rd].ch][1] = push_q[rd].d;
                n[push_q[rd].ch] = 2;
            end
            rd++;
        end
        for (int c = 0; c < NCH; c++) begin
            while (keep_full[c] && n[c] < 2) begin
                if (n[c] == 0) m[c][0] = seq;
                else m[c][1] = seq;
                n[c] = n[c] + 1;
                seq = seq + 16'h1;
            end
        end
        for (int c = 0; c < NCH; c++) begin
            cnt[c]    <= n[c];
            mem[c][0] <= m[c][0];
            mem[c][1] <= m[c][1];
        end
        push_rd  <= rd;
        fill_seq <= seq;
    end

    always_comb begin
        fifo_full  = '0;
        fifo_empty = '0;
        for (int c = 0; c < NCH; c++) begin
            fifo_full[c]  = (cnt[c] == 2);
            fifo_empty[c] = (cnt[c] == 0);
        end
    end

    assign fifo_pop_data = {pdata[3], pdata[2], pdata[1], pdata[0]};

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input int c, input logic [15:0] v);
        push_q.push_back('{ch: c, d: v});
    endtask

    task automatic do_start();
        @(negedge clk);
        start     = 1'b1;
        base_addr = 32'h0000_1000;
        ch_stride = 32'h0000_0100;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_write(output logic [31:0] a, output logic [31:0] w, output logic [3:0] e);
        bit seen;
        seen = 1'b0;
        a = '0;
        w = '0;
        e = '0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (glb_req && glb_gnt) begin
                seen  = 1'b1;
                a     = glb_addr;
                w     = glb_wdata;
                e     = glb_we;
                flush = 1'b0;
            end
        end
        if (!seen) begin
            n_chk++;
            n_err++;
            $display("FAIL write_timeout: got no accepted write, expected one within 60 cycles");
        end else begin
            n_wr++;
            $display("write %0d: addr=0x%08h wdata=0x%08h we=%b", n_wr, a, w, e);
        end
    endtask

    task automatic wait_req();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (glb_req) seen = 1'b1;
        end
        if (!seen) begin
            n_chk++;
            n_err++;
            $display("FAIL req_timeout: got glb_req=0, expected 1 within 60 cycles");
        end
    endtask

    typedef struct {
        int          ch;
        int          n;
        logic [15:0] d0;
        logic [15:0] d1;
        bit          fl;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
    } vec_t;

`ifdef OPSUM_WB_RELU_EN
    localparam logic [31:0] EXP_NEG_SINGLE = 32'h0000_0000;
    localparam logic [31:0] EXP_NEG_PAIR   = 32'h0000_1234;
`else
    localparam logic [31:0] EXP_NEG_SINGLE = 32'h0000_8001;
    localparam logic [31:0] EXP_NEG_PAIR   = 32'hFFFF_1234;
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs [NV];
        logic [31:0] a, w, a0, w0;
        logic [3:0]  e, e0;
        logic [31:0] exp_sc4 [4];
        bit          stable;
        int          p1, p2;

        // base 0x1000, stride 0x100; offsets accumulate across rows
        vecs[0] = '{ch: 2, n: 2, d0: 16'h0003, d1: 16'h0002, fl: 1'b0, addr: 32'h1200, wdata: 32'h0002_0003, we: 4'b1111};
        vecs[1] = '{ch: 1, n: 1, d0: 16'h7001, d1: 16'h0000, fl: 1'b1, addr: 32'h1100, wdata: 32'h0000_7001, we: 4'b0011};
        vecs[2] = '{ch: 1, n: 2, d0: 16'h000A, d1: 16'h000B, fl: 1'b0, addr: 32'h1100, wdata: 32'h000A_0000, we: 4'b1100};
        vecs[3] = '{ch: 1, n: 1, d0: 16'h000C, d1: 16'h0000, fl: 1'b0, addr: 32'h1104, wdata: 32'h000C_000B, we: 4'b1111};
        vecs[4] = '{ch: 0, n: 1, d0: 16'h8001, d1: 16'h0000, fl: 1'b1, addr: 32'h1000, wdata: EXP_NEG_SINGLE, we: 4'b0011};
        vecs[5] = '{ch: 3, n: 2, d0: 16'h1234, d1: 16'hFFFF, fl: 1'b0, addr: 32'h1300, wdata: EXP_NEG_PAIR, we: 4'b1111};
        vecs[6] = '{ch: 2, n: 2, d0: 16'h0011, d1: 16'h0022, fl: 1'b0, addr: 32'h1204, wdata: 32'h0022_0011, we: 4'b1111};
        vecs[7] = '{ch: 0, n: 2, d0: 16'h0005, d1: 16'h0006, fl: 1'b0, addr: 32'h1000, wdata: 32'h0005_0000, we: 4'b1100};
        vecs[8] = '{ch: 0, n: 1, d0: 16'h0007, d1: 16'h0000, fl: 1'b0, addr: 32'h1004, wdata: 32'h0007_0006, we: 4'b1111};
        exp_sc4[0] = 32'h1000;
        exp_sc4[1] = 32'h1300;
        exp_sc4[2] = 32'h1004;
        exp_sc4[3] = 32'h1304;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",    32'(busy),         32'h0);
        check("rst_done",    32'(done),         32'h0);
        check("rst_pop_en",  32'(fifo_pop_en),  32'h0);
        check("rst_pop_mod", 32'(fifo_pop_mod), 32'h0);
        check("rst_req",     32'(glb_req),      32'h0);
        check("rst_addr",    glb_addr,          32'h0);
        check("rst_wdata",   glb_wdata,         32'h0);
        check("rst_we",      32'(glb_we),       32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'h0);

        do_start();
        check("start_busy", 32'(busy), 32'h1);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            push(vecs[i].ch, vecs[i].d0);
            if (vecs[i].n == 2) push(vecs[i].ch, vecs[i].d1);
            if (vecs[i].fl) begin
                @(negedge clk);
                flush = 1'b1;
            end
            wait_write(a, w, e);
            check($sformatf("v%0d_addr", i),  a,      vecs[i].addr);
            check($sformatf("v%0d_wdata", i), w,      vecs[i].wdata);
            check($sformatf("v%0d_we", i),    32'(e), 32'(vecs[i].we));
        end

        // Write held off by gnt: outputs frozen, no pops.
        @(negedge clk);
        glb_gnt = 1'b0;
        push(2, 16'h0033);
        push(2, 16'h0044);
        wait_req();
        a0 = glb_addr;
        w0 = glb_wdata;
        e0 = glb_we;
        check("stall_addr",  a0,      32'h1208);
        check("stall_wdata", w0,      32'h0044_0033);
        check("stall_we",    32'(e0), 32'hF);
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (!glb_req || glb_addr !== a0 || glb_wdata !== w0 || glb_we !== e0 || fifo_pop_en !== '0)
                stable = 1'b0;
        end
        check("stall_stable", 32'(stable), 32'h1);
        glb_gnt = 1'b1;
        $display("write %0d: addr=0x%08h wdata=0x%08h we=%b (after stall)", n_wr + 1, a0, w0, e0);
        n_wr++;
        @(negedge clk);
        check("stall_req_drop", 32'(glb_req), 32'h0);

        // Flush with everything empty terminates with a one-cycle done.
        check("pre_done", 32'(done), 32'h0);
        flush = 1'b1;
        @(negedge clk);
        check("done_pulse", 32'(done), 32'h1);
        @(negedge clk);
        check("done_drop", 32'(done), 32'h0);
        check("done_idle", 32'(busy), 32'h0);
        flush = 1'b0;
        @(negedge clk);
        check("done_once", 32'(done), 32'h0);

        // Reset during a pending write.
        do_start();
        glb_gnt = 1'b0;
        push(1, 16'h0101);
        push(1, 16'h0202);
        wait_req();
        rst_n = 1'b0;
        #1;
        check("rstw_req",    32'(glb_req),     32'h0);
        check("rstw_pop_en", 32'(fifo_pop_en), 32'h0);
        check("rstw_busy",   32'(busy),        32'h0);
        check("rstw_we",     32'(glb_we),      32'h0);
        @(negedge clk);
        rst_n   = 1'b1;
        glb_gnt = 1'b1;
        @(negedge clk);
        check("rstw_stay_idle", 32'(busy), 32'h0);

        // Two channels held full: strict alternation from ch0.
        do_start();
        p1 = pops[1];
        p2 = pops[2];
        keep_full = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            wait_write(a, w, e);
            check($sformatf("rr%0d_addr", k), a,      exp_sc4[k]);
            check($sformatf("rr%0d_we", k),   32'(e), 32'hF);
        end
        keep_full = '0;
        check("rr_no_pop_ch1", 32'(pops[1]), 32'(p1));
        check("rr_no_pop_ch2", 32'(pops[2]), 32'(p2));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
